// File: rtl/noc_link_pkg.sv
// -----------------------------------------------------------------------------
// noc_link_pkg
// Shared definitions for the NoC send/credit link. Used by the transmit side
// (noc_credit_sender) and by the receive buffer.
//   - Default link field widths (FLIT_WIDTH, USER_WIDTH, DEST_WIDTH)
//   - Packet-tracking FSM state type
//   - credit_width(): width needed to hold a credit count of 0..depth
// -----------------------------------------------------------------------------
package noc_link_pkg;

  localparam int FLIT_WIDTH = 128;
  localparam int USER_WIDTH = 32;
  localparam int DEST_WIDTH = 8;

  typedef enum logic {
    PKT_IDLE = 1'b0,
    PKT_BODY = 1'b1
  } noc_pkt_state_e;

  // Counter must represent the full depth as well as zero.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// -----------------------------------------------------------------------------
// noc_credit_counter
// Up/down counter of buffer slots, 0..DEPTH, reset to DEPTH. The sender uses it
// for available credits and the receive side for occupancy.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   consume        take one slot this cycle (caller guarantees nonzero)
//   ret            give one slot back this cycle
//   count          current value
//   nonzero        count != 0
//   overflow_err   sticky: a return arrived while already at DEPTH
// -----------------------------------------------------------------------------
module noc_credit_counter
  import noc_link_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW = credit_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          consume,
  input  logic          ret,
  output logic [CW-1:0] count,
  output logic          nonzero,
  output logic          overflow_err
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] r_count;
  logic          r_err;
  logic          w_overflow;

  // Simultaneous consume and return cancel, so only a lone return can overflow.
  assign w_overflow = ret && !consume && (r_count == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= FULL;
      r_err   <= 1'b0;
    end else begin
      if (w_overflow) begin
        r_err <= 1'b1;                  // count saturates, flag is sticky
      end else if (consume && !ret) begin
        r_count <= r_count - 1'b1;
      end else if (ret && !consume) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count        = r_count;
  assign nonzero      = (r_count != '0);
  assign overflow_err = r_err;

endmodule

// File: rtl/noc_credit_sender.sv
// -----------------------------------------------------------------------------
// noc_credit_sender
// Transmit end of the NoC send/credit link. Accepts flits from a local
// valid/ready source and launches each as a one-cycle send pulse, one cycle
// after acceptance, only while a downstream credit is available.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_data/in_dest/in_user/in_is_tail, in_valid, in_ready   local source
//   data_out/dest_out/user_out/is_tail_out, send_out         link output
//   credit_in                         one slot returned per pulse
//   credit_count                      credits available now
//   pkt_active                        head sent, tail not yet sent
//   credit_err                        sticky credit overflow flag
//   stall_cycles, flits_sent          statistics
// Build option: define NOC_CREDIT_SENDER_STATS_EN to implement the statistics
// counters; otherwise both outputs read 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module noc_credit_sender
  import noc_link_pkg::*;
#(
  parameter int FLIT_WIDTH   = noc_link_pkg::FLIT_WIDTH,
  parameter int USER_WIDTH   = noc_link_pkg::USER_WIDTH,
  parameter int DEST_WIDTH   = noc_link_pkg::DEST_WIDTH,
  parameter int BUFFER_DEPTH = 8,
  localparam int CREDIT_WIDTH = credit_width(BUFFER_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLIT_WIDTH-1:0]   in_data,
  input  logic [DEST_WIDTH-1:0]   in_dest,
  input  logic [USER_WIDTH-1:0]   in_user,
  input  logic                    in_is_tail,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [FLIT_WIDTH-1:0]   data_out,
  output logic [DEST_WIDTH-1:0]   dest_out,
  output logic [USER_WIDTH-1:0]   user_out,
  output logic                    is_tail_out,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    pkt_active,
  output logic                    credit_err,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             flits_sent
);

  logic w_nonzero;
  logic w_fire;

  noc_credit_counter #(
    .DEPTH (BUFFER_DEPTH)
  ) u_credits (
    .clk          (clk),
    .rst          (rst),
    .consume      (w_fire),
    .ret          (credit_in),
    .count        (credit_count),
    .nonzero      (w_nonzero),
    .overflow_err (credit_err)
  );

  // Ready depends only on the registered count (and reset), never on credit_in.
  assign in_ready = w_nonzero && !rst;
  assign w_fire   = in_valid && in_ready;

  // Link payload: no reset so these can sit in hyper registers; only
  // meaningful while send_out is high.
  logic [FLIT_WIDTH-1:0] r_data;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [USER_WIDTH-1:0] r_user;

  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_data <= in_data;
      r_dest <= in_dest;
      r_user <= in_user;
    end
  end

  // Control outputs and packet tracker. The FSM is purely observational.
  noc_pkt_state_e r_state;
  logic           r_send;
  logic           r_tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PKT_IDLE;
      r_send  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      r_send <= w_fire;
      if (w_fire) begin
        r_tail <= in_is_tail;
        case (r_state)
          PKT_IDLE: r_state <= in_is_tail ? PKT_IDLE : PKT_BODY;
          PKT_BODY: r_state <= in_is_tail ? PKT_IDLE : PKT_BODY;
          default:  r_state <= PKT_IDLE;
        endcase
      end
    end
  end

  assign data_out    = r_data;
  assign dest_out    = r_dest;
  assign user_out    = r_user;
  assign send_out    = r_send;
  assign is_tail_out = r_tail;
  assign pkt_active  = (r_state == PKT_BODY);

`ifdef NOC_CREDIT_SENDER_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flits_sent;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flits_sent   <= '0;
    end else begin
      if (in_valid && !in_ready) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_fire)                r_flits_sent   <= r_flits_sent + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flits_sent   = r_flits_sent;
`else
  assign stall_cycles = '0;
  assign flits_sent   = '0;
`endif

endmodule

// File: tb/tb_noc_credit_sender.sv
// -----------------------------------------------------------------------------
// tb_noc_credit_sender
// Directed bench for noc_credit_sender with BUFFER_DEPTH=4. Inputs change 1ns
// after a rising edge and outputs are checked there, before the next edge.
// -----------------------------------------------------------------------------
module tb_noc_credit_sender;

  localparam int FW = 128;
  localparam int UW = 32;
  localparam int DW = 8;
  localparam int BD = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic [FW-1:0] in_data;
  logic [DW-1:0] in_dest;
  logic [UW-1:0] in_user;
  logic          in_is_tail;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic [UW-1:0] user_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in;
  logic [CW-1:0] credit_count;
  logic          pkt_active;
  logic          credit_err;
  logic [31:0]   stall_cycles;
  logic [31:0]   flits_sent;

  int tests = 0;
  int fails = 0;

  noc_credit_sender #(
    .FLIT_WIDTH   (FW),
    .USER_WIDTH   (UW),
    .DEST_WIDTH   (DW),
    .BUFFER_DEPTH (BD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_dest      (in_dest),
    .in_user      (in_user),
    .in_is_tail   (in_is_tail),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_out     (data_out),
    .dest_out     (dest_out),
    .user_out     (user_out),
    .is_tail_out  (is_tail_out),
    .send_out     (send_out),
    .credit_in    (credit_in),
    .credit_count (credit_count),
    .pkt_active   (pkt_active),
    .credit_err   (credit_err),
    .stall_cycles (stall_cycles),
    .flits_sent   (flits_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_stall;
    logic [31:0] exp_flits;

    rst = 1'b1; in_data = '0; in_dest = '0; in_user = '0;
    in_is_tail = 1'b1; in_valid = 1'b0; credit_in = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_count", 128'(credit_count), 128'(BD));
    check("rst_send", 128'(send_out), 128'd0);
    check("rst_tail", 128'(is_tail_out), 128'd0);
    check("rst_pkt", 128'(pkt_active), 128'd0);
    check("rst_err", 128'(credit_err), 128'd0);
    check("rst_ready", 128'(in_ready), 128'd0);
    check("rst_stall", 128'(stall_cycles), 128'd0);
    check("rst_flits", 128'(flits_sent), 128'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 128'(in_ready), 128'd1);
    $display("[TB] reset checked");

    // Test 1: hold valid with no credit returns for 10 cycles
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = FW'(c + 32'h100);
      in_dest = DW'(c);
      in_user = UW'(c + 32'h50);
      tick();
      check("t1_send", 128'(send_out), 128'(c < 4));
      check("t1_count", 128'(credit_count), 128'((c < 3) ? (3 - c) : 0));
      if (c < 4) begin
        check("t1_data", 128'(data_out), 128'(c + 32'h100));
        check("t1_dest", 128'(dest_out), 128'(c));
      end
      $display("[TB] t1 cycle %0d send=%0b count=%0d", c, send_out, credit_count);
    end
    check("t1_ready", 128'(in_ready), 128'd0);

    // Test 6 (stats after 10 cycles of test 1)
`ifdef NOC_CREDIT_SENDER_STATS_EN
    exp_flits = 32'd4; exp_stall = 32'd6;
`else
    exp_flits = 32'd0; exp_stall = 32'd0;
`endif
    check("t6_flits", 128'(flits_sent), 128'(exp_flits));
    check("t6_stall", 128'(stall_cycles), 128'(exp_stall));
    $display("[TB] stats flits=%0d stall=%0d", flits_sent, stall_cycles);

    // Test 2: one credit returns, exactly one more flit goes out
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("t2_count1", 128'(credit_count), 128'd1);
    check("t2_ready", 128'(in_ready), 128'd1);
    check("t2_nosend", 128'(send_out), 128'd0);
    in_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_A5A5;
    in_dest = 8'h3C;
    in_user = 32'hCAFE_F00D;
    in_is_tail = 1'b0;
    tick();
    check("t2_send", 128'(send_out), 128'd1);
    check("t2_data", 128'(data_out), 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_A5A5);
    check("t2_dest", 128'(dest_out), 128'h3C);
    check("t2_user", 128'(user_out), 128'hCAFE_F00D);
    check("t2_tail", 128'(is_tail_out), 128'd0);
    check("t2_count0", 128'(credit_count), 128'd0);
    in_is_tail = 1'b1;
    tick();
    check("t2_send_end", 128'(send_out), 128'd0);
    check("t2_count_end", 128'(credit_count), 128'd0);
    $display("[TB] t2 one extra flit done");

    // Test 3: count=1, credit every cycle -> 100 back-to-back flits in order
    in_valid = 1'b0;
    credit_in = 1'b1;
    tick();
    check("t3_count_start", 128'(credit_count), 128'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = FW'(i);
      tick();
      check("t3_send", 128'(send_out), 128'd1);
      check("t3_data", 128'(data_out), 128'(i));
      check("t3_count", 128'(credit_count), 128'd1);
    end
    $display("[TB] t3 100 streamed flits checked");
    in_valid = 1'b0;
    credit_in = 1'b0;
    tick();
    check("t3_idle_send", 128'(send_out), 128'd0);

    // Test 4: refill to 4, then an extra credit overflows
    credit_in = 1'b1;
    tick(); tick(); tick();
    check("t4_full", 128'(credit_count), 128'd4);
    check("t4_noerr", 128'(credit_err), 128'd0);
    tick();
    credit_in = 1'b0;
    check("t4_sat", 128'(credit_count), 128'd4);
    check("t4_err", 128'(credit_err), 128'd1);
    for (int i = 0; i < 10; i++) tick();
    check("t4_sticky", 128'(credit_err), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_cleared", 128'(credit_err), 128'd0);
    $display("[TB] t4 overflow flag checked");

    // Test 5: head, body, body, tail, single-flit tail
    check("t5_pkt_init", 128'(pkt_active), 128'd0);
    in_valid = 1'b1;
    credit_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_is_tail = (i >= 3);
      in_data = FW'(i + 32'h200);
      tick();
      check("t5_pkt", 128'(pkt_active), 128'((i < 3) ? 1 : 0));
      check("t5_tail_out", 128'(is_tail_out), 128'((i >= 3) ? 1 : 0));
      check("t5_count", 128'(credit_count), 128'd4);
      $display("[TB] t5 flit %0d pkt_active=%0b", i, pkt_active);
    end

    // Reset in the middle of a packet
    credit_in = 1'b0;
    in_is_tail = 1'b0;
    tick(); tick();
    check("t5_mid_pkt", 128'(pkt_active), 128'd1);
    check("t5_mid_count", 128'(credit_count), 128'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("t5_rst_pkt", 128'(pkt_active), 128'd0);
    check("t5_rst_count", 128'(credit_count), 128'd4);
    check("t5_rst_send", 128'(send_out), 128'd0);
    check("t5_rst_flits", 128'(flits_sent), 128'd0);
    rst = 1'b0;
    tick();
    $display("[TB] t5 reset mid-packet checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
